sram_like_arbiter: RTL and testbench

//  Shares one sram_like memory port between the fetch stage (inst_*) and the
//  MEM stage (data_*). Sits between the CPU core and the AXI bridge.

---
 rtl/sram_like_arbiter.sv | 148 ++++++++++++++
 tb/tb_sram_like_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_like_arbiter.sv
// Shares one sram_like port between the fetch (inst_*) and MEM (data_*) masters,
// routing each in-order response back to its issuer via a small owner FIFO.
module sram_like_arbiter #(
  parameter int unsigned MAX_OUT      = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        arb_err
);

  localparam int unsigned PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUT) + 1;
  localparam int unsigned SC_W  = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOCK_I = 2'd1,
    S_LOCK_D = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              sel_data;
  logic              owner_q [MAX_OUT];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [SC_W-1:0]   starve_q;
  logic              fifo_full, fifo_empty, starved;
  logic              accept, pop, head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUT - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign fifo_full  = (count_q == CNT_W'(MAX_OUT));
  assign fifo_empty = (count_q == '0);
  assign starved    = (starve_q == SC_W'(STARVE_LIMIT));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Grant selection; a pending request keeps its master until accepted or cancelled
  always_comb begin
    state_d  = state_q;
    sel_data = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        if (!fifo_full) begin
          if (data_req && !(starved && inst_req)) begin
            sel_data = 1'b1;
            if (!mem_addr_ok) state_d = S_LOCK_D;
          end else if (inst_req) begin
            sel_data = 1'b0;
            if (!mem_addr_ok) state_d = S_LOCK_I;
          end
        end
      end
      S_LOCK_I: begin
        sel_data = 1'b0;
        if (!inst_req || mem_addr_ok) state_d = S_IDLE;
      end
      S_LOCK_D: begin
        sel_data = 1'b1;
        if (!data_req || mem_addr_ok) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bridge interface stays quiet while reset is asserted, even with requests held
  assign mem_req   = (sel_data ? data_req : inst_req) & ~fifo_full & resetn;
  assign mem_wr    = sel_data ? data_wr    : inst_wr;
  assign mem_size  = sel_data ? data_size  : inst_size;
  assign mem_addr  = sel_data ? data_addr  : inst_addr;
  assign mem_wdata = sel_data ? data_wdata : inst_wdata;

  assign accept       = mem_req & mem_addr_ok;
  assign inst_addr_ok = accept & ~sel_data;
  assign data_addr_ok = accept &  sel_data;

  assign pop          = mem_data_ok & ~fifo_empty;
  assign head         = owner_q[rd_ptr_q];
  assign inst_data_ok = pop & ~head;
  assign data_data_ok = pop &  head;
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  // Owner FIFO: 0 = inst, 1 = data, in issue order
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(MAX_OUT); i++) owner_q[i] <= 1'b0;
    end else begin
      if (accept) begin
        owner_q[wr_ptr_q] <= sel_data;
        wr_ptr_q          <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (accept && !pop)      count_q <= count_q + CNT_W'(1);
      else if (!accept && pop) count_q <= count_q - CNT_W'(1);
    end
  end

  // Counts data accepts that overtake a waiting fetch
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_q <= '0;
    end else if (!inst_req || inst_addr_ok) begin
      starve_q <= '0;
    end else if (data_addr_ok && !starved) begin
      starve_q <= starve_q + SC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                        arb_err <= 1'b0;
    else if (mem_data_ok && fifo_empty) arb_err <= 1'b1;
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Self-checking bench for sram_like_arbiter: directed scenarios plus random traffic
// compared every cycle against a queue-based reference model.
module tb_sram_like_arbiter;

  localparam int unsigned MAX_OUT      = 2;
  localparam int unsigned STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic        arb_err;

  sram_like_arbiter #(.MAX_OUT(MAX_OUT), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .arb_err(arb_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: owners of outstanding requests, starvation count,
  // master holding an unaccepted grant (-1 none, 0 inst, 1 data), sticky error.
  int q[$];
  int sc     = 0;
  int lock   = -1;
  bit err_m  = 1'b0;
  bit last_i_acc = 1'b0;
  bit last_d_acc = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    inst_req = 1'b0; inst_wr = 1'b0; inst_size = 2'd0; inst_addr = '0; inst_wdata = '0;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_addr = '0; data_wdata = '0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
  endtask

  task automatic settle();
    #2;
  endtask

  // Compare all outputs with the model, advance the model across the clock edge
  task automatic commit();
    bit full, sel, ereq, acc, pop;
    int head;
    full = (q.size() == int'(MAX_OUT));
    if (lock >= 0)                                                  sel = (lock == 1);
    else if (!full && data_req && !(sc == int'(STARVE_LIMIT) && inst_req)) sel = 1'b1;
    else if (!full && inst_req)                                     sel = 1'b0;
    else                                                            sel = 1'b1;
    ereq = (sel ? data_req : inst_req) && !full;
    acc  = ereq && mem_addr_ok;
    pop  = mem_data_ok && (q.size() > 0);
    head = pop ? q[0] : -1;

    chk("mem_req",      32'(mem_req),      32'(ereq));
    chk("mem_wr",       32'(mem_wr),       32'(sel ? data_wr : inst_wr));
    chk("mem_size",     32'(mem_size),     32'(sel ? data_size : inst_size));
    chk("mem_addr",     mem_addr,          sel ? data_addr : inst_addr);
    chk("mem_wdata",    mem_wdata,         sel ? data_wdata : inst_wdata);
    chk("inst_addr_ok", 32'(inst_addr_ok), 32'(acc && !sel));
    chk("data_addr_ok", 32'(data_addr_ok), 32'(acc && sel));
    chk("inst_data_ok", 32'(inst_data_ok), 32'(pop && head == 0));
    chk("data_data_ok", 32'(data_data_ok), 32'(pop && head == 1));
    chk("inst_rdata",   inst_rdata,        mem_rdata);
    chk("data_rdata",   data_rdata,        mem_rdata);
    chk("arb_err",      32'(arb_err),      32'(err_m));

    if (mem_data_ok && q.size() == 0) err_m = 1'b1;
    if (pop) void'(q.pop_front());
    if (acc) q.push_back(int'(sel));
    lock = (ereq && !acc) ? int'(sel) : -1;
    if (!inst_req || (acc && !sel))                   sc = 0;
    else if (acc && sel && sc < int'(STARVE_LIMIT))   sc++;
    last_i_acc = acc && !sel;
    last_d_acc = acc && sel;
    @(posedge clk);
    #1;
  endtask

  // Assert reset mid-cycle with whatever inputs are live, check quiet outputs
  task automatic apply_reset();
    resetn = 1'b0;
    #1;
    chk("rst_mem_req",      32'(mem_req),      0);
    chk("rst_inst_addr_ok", 32'(inst_addr_ok), 0);
    chk("rst_data_addr_ok", 32'(data_addr_ok), 0);
    chk("rst_inst_data_ok", 32'(inst_data_ok), 0);
    chk("rst_data_data_ok", 32'(data_data_ok), 0);
    chk("rst_arb_err",      32'(arb_err),      0);
    q.delete();
    sc = 0; lock = -1; err_m = 1'b0;
    last_i_acc = 1'b0; last_d_acc = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    idle_inputs();
  endtask

  task automatic randomize_inputs();
    if (!inst_req || last_i_acc || $urandom_range(0, 19) == 0) begin
      inst_req   = ($urandom_range(0, 2) != 0);
      inst_wr    = 1'b0;
      inst_size  = 2'($urandom_range(0, 2));
      inst_addr  = $urandom;
      inst_wdata = $urandom;
    end
    if (!data_req || last_d_acc || $urandom_range(0, 19) == 0) begin
      data_req   = ($urandom_range(0, 2) != 0);
      data_wr    = 1'($urandom_range(0, 1));
      data_size  = 2'($urandom_range(0, 2));
      data_addr  = $urandom;
      data_wdata = $urandom;
    end
    mem_addr_ok = 1'($urandom_range(0, 1));
    mem_data_ok = (q.size() > 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 99) == 0);
    mem_rdata   = $urandom;
  endtask

  initial begin
    idle_inputs();
    @(posedge clk);
    #1;
    apply_reset();

    // Single fetch, response two cycles after accept
    inst_req = 1'b1; inst_addr = 32'hBFC0_0000; inst_size = 2'd2; mem_addr_ok = 1'b1;
    settle();
    chk("t1_inst_addr_ok", 32'(inst_addr_ok), 1);
    chk("t1_mem_addr", mem_addr, 32'hBFC0_0000);
    commit();
    inst_req = 1'b0; mem_addr_ok = 1'b0;
    settle();
    chk("t1_c1_inst_data_ok", 32'(inst_data_ok), 0);
    commit();
    mem_data_ok = 1'b1; mem_rdata = 32'h3C1D_BFC0;
    settle();
    chk("t1_inst_data_ok", 32'(inst_data_ok), 1);
    chk("t1_inst_rdata", inst_rdata, 32'h3C1D_BFC0);
    chk("t1_data_data_ok", 32'(data_data_ok), 0);
    commit();
    mem_data_ok = 1'b0;

    // Both request, bridge stalls; data stays selected while inst_addr moves
    inst_req = 1'b1; data_req = 1'b1; data_wr = 1'b1;
    data_addr = 32'h1000_0040; data_wdata = 32'hA5A5_5A5A; mem_addr_ok = 1'b0;
    for (int i = 0; i < 3; i++) begin
      inst_addr = 32'h2000_0000 + 32'(i * 4);
      settle();
      chk("t2_mem_addr", mem_addr, 32'h1000_0040);
      chk("t2_mem_req", 32'(mem_req), 1);
      chk("t2_data_addr_ok", 32'(data_addr_ok), 0);
      commit();
    end
    mem_addr_ok = 1'b1; inst_addr = 32'h2000_0100;
    settle();
    chk("t2_data_addr_ok", 32'(data_addr_ok), 1);
    chk("t2_inst_addr_ok", 32'(inst_addr_ok), 0);
    commit();

    // Fill the FIFO (data, inst), third request held, responses routed in order
    data_req = 1'b0;
    settle();
    chk("t3_inst_addr_ok", 32'(inst_addr_ok), 1);
    commit();
    inst_req = 1'b0; data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h1000_0080;
    settle();
    chk("t3_full_mem_req", 32'(mem_req), 0);
    chk("t3_full_data_addr_ok", 32'(data_addr_ok), 0);
    commit();
    mem_data_ok = 1'b1; mem_rdata = 32'h1111_2222;
    settle();
    chk("t3_first_data_data_ok", 32'(data_data_ok), 1);
    chk("t3_first_inst_data_ok", 32'(inst_data_ok), 0);
    chk("t3_pop_full_mem_req", 32'(mem_req), 0);
    commit();
    mem_addr_ok = 1'b0; mem_rdata = 32'h3333_4444;
    settle();
    chk("t3_second_inst_data_ok", 32'(inst_data_ok), 1);
    chk("t3_second_data_data_ok", 32'(data_data_ok), 0);
    chk("t3_third_mem_req", 32'(mem_req), 1);
    commit();
    mem_data_ok = 1'b0; mem_addr_ok = 1'b1;
    settle();
    chk("t3_third_data_addr_ok", 32'(data_addr_ok), 1);
    commit();
    data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
    settle();
    chk("t3_third_data_data_ok", 32'(data_data_ok), 1);
    commit();
    mem_data_ok = 1'b0;

    // Starvation override after STARVE_LIMIT data accepts
    apply_reset();
    inst_req = 1'b1; inst_addr = 32'hBFC0_0100; data_req = 1'b1;
    data_addr = 32'h1000_0200; mem_addr_ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      mem_data_ok = (i > 0);
      settle();
      if (i < 4) begin
        chk("t4_data_addr_ok", 32'(data_addr_ok), 1);
        chk("t4_inst_addr_ok", 32'(inst_addr_ok), 0);
      end else if (i == 4) begin
        chk("t4_forced_inst_addr_ok", 32'(inst_addr_ok), 1);
        chk("t4_forced_data_addr_ok", 32'(data_addr_ok), 0);
      end else begin
        chk("t4_after_data_addr_ok", 32'(data_addr_ok), 1);
      end
      commit();
    end
    inst_req = 1'b0; data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
    settle();
    commit();
    mem_data_ok = 1'b0;

    // Response with nothing outstanding sets a sticky error
    mem_data_ok = 1'b1;
    settle();
    chk("t5_inst_data_ok", 32'(inst_data_ok), 0);
    chk("t5_data_data_ok", 32'(data_data_ok), 0);
    commit();
    mem_data_ok = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("t5_arb_err_sticky", 32'(arb_err), 1);
      commit();
    end
    apply_reset();

    // Reset while a data request is locked with one entry outstanding
    data_req = 1'b1; data_addr = 32'h1000_0300; mem_addr_ok = 1'b1;
    settle();
    commit();
    data_addr = 32'h1000_0304; mem_addr_ok = 1'b0;
    settle();
    chk("t6_locked_mem_req", 32'(mem_req), 1);
    commit();
    mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
    apply_reset();
    inst_req = 1'b1; inst_addr = 32'hBFC0_0200; mem_addr_ok = 1'b1;
    settle();
    chk("t6_inst_addr_ok", 32'(inst_addr_ok), 1);
    chk("t6_mem_addr", mem_addr, 32'hBFC0_0200);
    commit();
    inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
    settle();
    chk("t6_inst_data_ok", 32'(inst_data_ok), 1);
    chk("t6_arb_err", 32'(arb_err), 0);
    commit();
    mem_data_ok = 1'b0;

    // Random traffic with occasional asynchronous resets
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 499) == 0) apply_reset();
      randomize_inputs();
      settle();
      commit();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
